pe_acc_drain: RTL and testbench

//  Output-drain stage directly downstream of a PE column. It captures ACC_BW accumulator

---
 rtl/pe_acc_drain_if.sv | 26 ++
 rtl/pe_acc_drain.sv | 132 +++++++++++++
 tb/tb_pe_acc_drain.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_acc_drain_if.sv
// Stream bundle for pe_acc_drain.
//   Input side : in_vld_i / in_rdy_o / acc_i  (ACC_BW-bit signed accumulator results)
//   Output side: out_vld_o / out_rdy_i / out_data_o / out_last_o (MUL_BW-bit quantised beats)
// The slave modport is the drain stage; the master modport is the PE column plus consumer.
interface pe_acc_drain_if #(
    parameter int ACC_BW = 32,
    parameter int MUL_BW = 16
);
    logic              in_vld_i;
    logic              in_rdy_o;
    logic [ACC_BW-1:0] acc_i;
    logic              out_vld_o;
    logic              out_rdy_i;
    logic [MUL_BW-1:0] out_data_o;
    logic              out_last_o;

    modport slave (
        input  in_vld_i, acc_i, out_rdy_i,
        output in_rdy_o, out_vld_o, out_data_o, out_last_o
    );

    modport master (
        output in_vld_i, acc_i, out_rdy_i,
        input  in_rdy_o, out_vld_o, out_data_o, out_last_o
    );
endinterface

// File: rtl/pe_acc_drain.sv
// Output-drain stage behind a PE column. Accumulator results (2*FRA_BW fraction bits)
// are ReLU'd (optional), rounded half-up to FRA_BW fraction bits, saturated to the
// signed INT_BW.FRA_BW range, sign-extended to MUL_BW and streamed out through a FIFO
// with a tile-boundary last flag.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear_i      synchronous flush of pipeline, FIFO, beat counter and sat counter
//   relu_i       force negative results to zero before rounding
//   tile_len_i   beats per tile (0 behaves as 1)
//   sat_cnt_o    saturating count of clipped inputs
//   bus          stream interface (slave side): input and output handshakes
module pe_acc_drain #(
    parameter int INT_BW = 5,
    parameter int FRA_BW = 3,
    parameter int MUL_BW = 16,
    parameter int ACC_BW = 32,
    parameter int DEPTH  = 8,
    parameter int LEN_BW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              relu_i,
    input  logic [LEN_BW-1:0] tile_len_i,
    output logic [15:0]       sat_cnt_o,
    pe_acc_drain_if.slave     bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int Q_W   = INT_BW + FRA_BW;
    localparam logic signed [ACC_BW:0] SAT_MAX  = (ACC_BW+1)'((1 << Q_W) - 1);
    localparam logic signed [ACC_BW:0] SAT_MIN  = -(ACC_BW+1)'(1 << Q_W);
    localparam logic signed [ACC_BW:0] RND_HALF = (ACC_BW+1)'(1 << (FRA_BW-1));

    logic signed [ACC_BW-1:0] v;
    logic signed [ACC_BW:0]   v_rnd;
    logic signed [ACC_BW:0]   r;
    logic signed [ACC_BW:0]   q;
    logic                     q_sat;

    logic              s1_vld;
    logic [MUL_BW-1:0] s1_data;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  fifo_cnt;
    logic [PTR_W:0]    fill;
    logic [MUL_BW-1:0] mem [DEPTH];
    logic [MUL_BW-1:0] hold_q;
    logic [LEN_BW-1:0] beat;
    logic [LEN_BW-1:0] len_m1;
    logic              in_fire;
    logic              out_fire;

    // Rounding is done one bit wider than the accumulator so the +half cannot wrap.
    always_comb begin
        v = $signed(bus.acc_i);
        if (relu_i && bus.acc_i[ACC_BW-1]) begin
            v = '0;
        end
        v_rnd = $signed({v[ACC_BW-1], v}) + RND_HALF;
        r     = v_rnd >>> FRA_BW;
        q     = r;
        q_sat = 1'b0;
        if (r > SAT_MAX) begin
            q     = SAT_MAX;
            q_sat = 1'b1;
        end else if (r < SAT_MIN) begin
            q     = SAT_MIN;
            q_sat = 1'b1;
        end
    end

    // Ready looks only at registered occupancy, counting the beat still in s1,
    // so a beat accepted now always has a free FIFO slot when it leaves s1.
    assign fifo_cnt     = wr_ptr - rd_ptr;
    assign fill         = {1'b0, fifo_cnt} + {{PTR_W{1'b0}}, s1_vld};
    assign bus.in_rdy_o = fill < (PTR_W+1)'(DEPTH);
    assign in_fire      = bus.in_vld_i & bus.in_rdy_o;

    assign bus.out_vld_o = fifo_cnt != '0;
    assign out_fire      = bus.out_vld_o & bus.out_rdy_i;

    // When empty, show the last word popped (hold_q) rather than a stale slot.
    assign bus.out_data_o = bus.out_vld_o ? mem[rd_ptr[AW-1:0]] : hold_q;

    // ">=" lets a counter left beyond a newly shortened tile close the tile on its next beat.
    assign len_m1         = (tile_len_i == '0) ? '0 : tile_len_i - LEN_BW'(1);
    assign bus.out_last_o = bus.out_vld_o & (beat >= len_m1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld    <= 1'b0;
            s1_data   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            hold_q    <= '0;
            beat      <= '0;
            sat_cnt_o <= '0;
        end else if (clear_i) begin
            s1_vld    <= 1'b0;
            s1_data   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            hold_q    <= '0;
            beat      <= '0;
            sat_cnt_o <= '0;
        end else begin
            s1_vld <= in_fire;
            if (in_fire) begin
                s1_data <= q[MUL_BW-1:0];
                if (q_sat && (sat_cnt_o != 16'hFFFF)) begin
                    sat_cnt_o <= sat_cnt_o + 16'd1;
                end
            end
            if (s1_vld) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (out_fire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                hold_q <= mem[rd_ptr[AW-1:0]];
                beat   <= bus.out_last_o ? '0 : beat + LEN_BW'(1);
            end
        end
    end

    // Storage needs no reset: pointers define which slots are meaningful.
    always_ff @(posedge clk) begin
        if (s1_vld && !clear_i) begin
            mem[wr_ptr[AW-1:0]] <= s1_data;
        end
    end
endmodule

// File: tb/tb_pe_acc_drain.sv
module tb_pe_acc_drain;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear_i = 1'b0;
    logic        relu_i = 1'b0;
    logic [7:0]  tile_len_i = 8'd1;
    logic [15:0] sat_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    pe_acc_drain_if #(.ACC_BW(32), .MUL_BW(16)) bus();

    pe_acc_drain #(
        .INT_BW(5), .FRA_BW(3), .MUL_BW(16), .ACC_BW(32), .DEPTH(8), .LEN_BW(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (clear_i),
        .relu_i     (relu_i),
        .tile_len_i (tile_len_i),
        .sat_cnt_o  (sat_cnt_o),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single beat with a free-running consumer; returns what is seen two cycles after acceptance.
    task automatic one_beat(input logic [31:0] a, input logic r,
                            output logic vld, output logic [15:0] data);
        relu_i        = r;
        bus.out_rdy_i = 1'b1;
        bus.in_vld_i  = 1'b1;
        bus.acc_i     = a;
        step();
        bus.in_vld_i  = 1'b0;
        step();
        vld  = bus.out_vld_o;
        data = bus.out_data_o;
        step();
        relu_i = 1'b0;
    endtask

    // Enqueue n beats (FIFO assumed empty, consumer stalled); data of beat i is base+i.
    task automatic fill(input int n, input int base, input logic sat_all);
        for (int i = 0; i < n; i++) begin
            bus.in_vld_i = 1'b1;
            bus.acc_i    = sat_all ? 32'h0001_0000 : 32'((base + i) * 8);
            step();
        end
        bus.in_vld_i = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        n_tests++;
        if (bus.in_rdy_o !== 1'b1) begin n_fail++; $display("FAIL reset_in_rdy got %b exp 1", bus.in_rdy_o); end
        n_tests++;
        if (bus.out_vld_o !== 1'b0) begin n_fail++; $display("FAIL reset_out_vld got %b exp 0", bus.out_vld_o); end
        n_tests++;
        if (bus.out_data_o !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data got %h exp 0000", bus.out_data_o); end
        n_tests++;
        if (bus.out_last_o !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got %b exp 0", bus.out_last_o); end
        n_tests++;
        if (sat_cnt_o !== 16'h0000) begin n_fail++; $display("FAIL reset_sat_cnt got %h exp 0000", sat_cnt_o); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        tile_len_i    = 8'd1;
        bus.out_rdy_i = 1'b1;
        bus.in_vld_i  = 1'b1;
        bus.acc_i     = 32'd84;
        step();
        bus.in_vld_i  = 1'b0;
        n_tests++;
        if (bus.out_vld_o !== 1'b0) begin n_fail++; $display("FAIL basic_early_vld got %b exp 0", bus.out_vld_o); end
        step();
        n_tests++;
        if (bus.out_vld_o !== 1'b1 || bus.out_data_o !== 16'h000B)
            begin n_fail++; $display("FAIL basic_84 got vld=%b data=%h exp vld=1 data=000b", bus.out_vld_o, bus.out_data_o); end
        n_tests++;
        if (bus.out_last_o !== 1'b1) begin n_fail++; $display("FAIL basic_last got %b exp 1", bus.out_last_o); end
        step();
        n_tests++;
        if (bus.out_vld_o !== 1'b0 || bus.out_data_o !== 16'h000B)
            begin n_fail++; $display("FAIL basic_hold got vld=%b data=%h exp vld=0 data=000b", bus.out_vld_o, bus.out_data_o); end
        n_tests++;
        if (sat_cnt_o !== 16'h0000) begin n_fail++; $display("FAIL basic_sat got %h exp 0000", sat_cnt_o); end
    endtask

    task automatic test_round();
        logic        vld;
        logic [15:0] d;
        one_beat(32'hFFFF_FFF4, 1'b0, vld, d);
        n_tests++;
        if (vld !== 1'b1 || d !== 16'hFFFF) begin n_fail++; $display("FAIL round_m12 got vld=%b data=%h exp 1 ffff", vld, d); end
        one_beat(32'hFFFF_FFF4, 1'b1, vld, d);
        n_tests++;
        if (vld !== 1'b1 || d !== 16'h0000) begin n_fail++; $display("FAIL relu_m12 got vld=%b data=%h exp 1 0000", vld, d); end
        one_beat(32'd4, 1'b0, vld, d);
        n_tests++;
        if (vld !== 1'b1 || d !== 16'h0001) begin n_fail++; $display("FAIL round_half_4 got vld=%b data=%h exp 1 0001", vld, d); end
        one_beat(32'd3, 1'b0, vld, d);
        n_tests++;
        if (vld !== 1'b1 || d !== 16'h0000) begin n_fail++; $display("FAIL round_down_3 got vld=%b data=%h exp 1 0000", vld, d); end
        n_tests++;
        if (sat_cnt_o !== 16'h0000) begin n_fail++; $display("FAIL round_sat got %h exp 0000", sat_cnt_o); end
    endtask

    task automatic test_saturate();
        logic        vld;
        logic [15:0] d;
        one_beat(32'h0001_0000, 1'b0, vld, d);
        n_tests++;
        if (d !== 16'h00FF) begin n_fail++; $display("FAIL sat_pos got %h exp 00ff", d); end
        one_beat(32'h8000_0000, 1'b0, vld, d);
        n_tests++;
        if (d !== 16'hFF00) begin n_fail++; $display("FAIL sat_neg got %h exp ff00", d); end
        n_tests++;
        if (sat_cnt_o !== 16'd2) begin n_fail++; $display("FAIL sat_cnt2 got %0d exp 2", sat_cnt_o); end
        one_beat(32'd2043, 1'b0, vld, d);
        n_tests++;
        if (d !== 16'h00FF || sat_cnt_o !== 16'd2) begin n_fail++; $display("FAIL edge_2043 got data=%h sat=%0d exp 00ff 2", d, sat_cnt_o); end
        one_beat(32'd2044, 1'b0, vld, d);
        n_tests++;
        if (d !== 16'h00FF || sat_cnt_o !== 16'd3) begin n_fail++; $display("FAIL edge_2044 got data=%h sat=%0d exp 00ff 3", d, sat_cnt_o); end
        one_beat(32'hFFFF_F800, 1'b0, vld, d);
        n_tests++;
        if (d !== 16'hFF00 || sat_cnt_o !== 16'd3) begin n_fail++; $display("FAIL edge_m2048 got data=%h sat=%0d exp ff00 3", d, sat_cnt_o); end
    endtask

    task automatic test_backpressure();
        int   accepted = 0;
        logic take;
        bus.out_rdy_i = 1'b0;
        for (int c = 0; c < 14; c++) begin
            bus.in_vld_i = 1'b1;
            bus.acc_i    = 32'(accepted * 8);
            take         = bus.in_rdy_o;
            step();
            if (take) accepted++;
        end
        bus.in_vld_i = 1'b0;
        n_tests++;
        if (accepted != 8) begin n_fail++; $display("FAIL bp_accepted got %0d exp 8", accepted); end
        n_tests++;
        if (bus.in_rdy_o !== 1'b0) begin n_fail++; $display("FAIL bp_in_rdy got %b exp 0", bus.in_rdy_o); end
        step();
        step();
        n_tests++;
        if (bus.out_vld_o !== 1'b1 || bus.out_data_o !== 16'h0000 || bus.out_last_o !== 1'b1)
            begin n_fail++; $display("FAIL bp_stable got vld=%b data=%h last=%b exp 1 0000 1", bus.out_vld_o, bus.out_data_o, bus.out_last_o); end
        bus.out_rdy_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            n_tests++;
            if (bus.out_vld_o !== 1'b1 || bus.out_data_o !== 16'(k))
                begin n_fail++; $display("FAIL bp_drain%0d got vld=%b data=%h exp 1 %h", k, bus.out_vld_o, bus.out_data_o, 16'(k)); end
            step();
        end
        n_tests++;
        if (bus.out_vld_o !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %b exp 0", bus.out_vld_o); end
        bus.out_rdy_i = 1'b0;
    endtask

    task automatic test_last();
        logic exp_last;
        bus.out_rdy_i = 1'b0;
        tile_len_i    = 8'd3;
        fill(7, 0, 1'b0);
        bus.out_rdy_i = 1'b1;
        for (int k = 0; k < 7; k++) begin
            exp_last = (k == 2) || (k == 5);
            n_tests++;
            if (bus.out_last_o !== exp_last || bus.out_data_o !== 16'(k))
                begin n_fail++; $display("FAIL last3_beat%0d got last=%b data=%h exp %b %h", k, bus.out_last_o, bus.out_data_o, exp_last, 16'(k)); end
            step();
        end
        bus.out_rdy_i = 1'b0;
        tile_len_i    = 8'd0;
        fill(3, 10, 1'b0);
        bus.out_rdy_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (bus.out_last_o !== 1'b1 || bus.out_data_o !== 16'(10 + k))
                begin n_fail++; $display("FAIL last0_beat%0d got last=%b data=%h exp 1 %h", k, bus.out_last_o, bus.out_data_o, 16'(10 + k)); end
            step();
        end
        bus.out_rdy_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        tile_len_i    = 8'd1;
        bus.out_rdy_i = 1'b0;
        fill(5, 0, 1'b1);
        n_tests++;
        if (bus.out_vld_o !== 1'b1 || sat_cnt_o !== 16'd8)
            begin n_fail++; $display("FAIL rst_pre got vld=%b sat=%0d exp 1 8", bus.out_vld_o, sat_cnt_o); end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.out_vld_o !== 1'b0 || sat_cnt_o !== 16'd0 || bus.in_rdy_o !== 1'b1)
            begin n_fail++; $display("FAIL rst_async got vld=%b sat=%0d rdy=%b exp 0 0 1", bus.out_vld_o, sat_cnt_o, bus.in_rdy_o); end
        step();
        rst_n = 1'b1;
        step();

        tile_len_i = 8'd3;
        fill(5, 20, 1'b1);
        bus.out_rdy_i = 1'b1;
        step();
        step();
        bus.out_rdy_i = 1'b0;
        n_tests++;
        if (bus.out_last_o !== 1'b1 || sat_cnt_o !== 16'd5)
            begin n_fail++; $display("FAIL clr_pre got last=%b sat=%0d exp 1 5", bus.out_last_o, sat_cnt_o); end
        clear_i = 1'b1;
        #1;
        n_tests++;
        if (bus.out_vld_o !== 1'b1) begin n_fail++; $display("FAIL clr_sync got vld=%b exp 1", bus.out_vld_o); end
        step();
        clear_i = 1'b0;
        n_tests++;
        if (bus.out_vld_o !== 1'b0 || sat_cnt_o !== 16'd0 || bus.out_data_o !== 16'h0000 || bus.out_last_o !== 1'b0)
            begin n_fail++; $display("FAIL clr_state got vld=%b sat=%0d data=%h last=%b exp 0 0 0000 0", bus.out_vld_o, sat_cnt_o, bus.out_data_o, bus.out_last_o); end
        fill(2, 4, 1'b0);
        n_tests++;
        if (bus.out_data_o !== 16'h0004 || bus.out_last_o !== 1'b0)
            begin n_fail++; $display("FAIL clr_tile got data=%h last=%b exp 0004 0", bus.out_data_o, bus.out_last_o); end
    endtask

    initial begin
        bus.in_vld_i  = 1'b0;
        bus.acc_i     = '0;
        bus.out_rdy_i = 1'b0;
        test_reset();
        test_basic();
        test_round();
        test_saturate();
        test_backpressure();
        test_last();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
